pipo_rr_writer: RTL and testbench

Round-robin write arbiter and register bank for parallel-in/parallel-out storage: NREQ requesters share write access to NREGS registers of WIDTH bits, one committed write per clock. All register contents are presented in parallel on a flat output bus. A separate registered read port serves a single consumer. This block sits between multiple producer engines and the downstream PIPO storage they share.

---
 rtl/pipo_rr_writer.sv | 111 +++++++++++
 tb/tb_pipo_rr_writer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pipo_rr_writer.sv
// pipo_rr_writer: round-robin write arbiter in front of a PIPO register bank.
// One committed write per clock, parallel q_all view, registered read port.
module pipo_rr_writer #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int NREGS = 4,
    localparam int AW   = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   hold,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*AW-1:0]     req_addr,
    input  logic [NREQ*WIDTH-1:0]  req_data,
    output logic [NREQ-1:0]        gnt,
    input  logic [AW-1:0]          rd_addr,
    output logic [WIDTH-1:0]       rd_data,
    output logic [NREGS*WIDTH-1:0] q_all
);

    localparam int PW = $clog2(NREQ);

    logic [WIDTH-1:0] r_regs [NREGS];
    logic [PW-1:0]    r_ptr;

    logic [NREQ-1:0]  w_elig;
    logic             w_found;
    logic [PW-1:0]    w_win;
    logic [PW-1:0]    w_ptr_nxt;
    logic [NREQ-1:0]  w_onehot;
    logic [AW-1:0]    w_waddr;
    logic [WIDTH-1:0] w_wdata;
    logic             w_inrange;
    logic             w_rd_ok;
    logic             w_wen;

    // A requester granted last cycle sits out this one.
    assign w_elig = req & ~gnt;

    // Scan from the pointer upward, wrapping, and take the first eligible.
    always_comb begin
        int idx;
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!w_found && w_elig[idx]) begin
                w_found = 1'b1;
                w_win   = PW'(idx);
            end
        end
    end

    assign w_ptr_nxt = (w_win == PW'(NREQ - 1)) ? '0 : w_win + 1'b1;
    assign w_onehot  = NREQ'(1) << w_win;
    assign w_waddr   = req_addr[w_win*AW +: AW];
    assign w_wdata   = req_data[w_win*WIDTH +: WIDTH];

    // Address range checks only matter when NREGS leaves unused codes.
    generate
        if (NREGS == (1 << AW)) begin : g_full
            assign w_inrange = 1'b1;
            assign w_rd_ok   = 1'b1;
        end else begin : g_part
            assign w_inrange = (w_waddr < AW'(NREGS));
            assign w_rd_ok   = (rd_addr < AW'(NREGS));
        end
    endgenerate

    assign w_wen = !hold && w_found && w_inrange;

    // Arbitration state: grant pulse and round-robin pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt   <= '0;
            r_ptr <= '0;
        end else if (hold || !w_found) begin
            gnt   <= '0;
        end else begin
            gnt   <= w_onehot;
            r_ptr <= w_ptr_nxt;
        end
    end

    // Register bank: the winning requester's write lands this edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NREGS; k++) r_regs[k] <= '0;
        end else if (w_wen) begin
            r_regs[w_waddr] <= w_wdata;
        end
    end

    // Read port returns pre-edge contents, independent of hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= w_rd_ok ? r_regs[rd_addr] : '0;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NREGS; g++) begin : g_q
            assign q_all[g*WIDTH +: WIDTH] = r_regs[g];
        end
    endgenerate

endmodule

// File: tb/tb_pipo_rr_writer.sv
// tb_pipo_rr_writer: directed checks of arbitration order, writes,
// hold, collisions, async reset and read-during-write.
module tb_pipo_rr_writer;

    logic        clk;
    logic        reset;
    logic        hold;
    logic [3:0]  req;
    logic [7:0]  req_addr;
    logic [15:0] req_data;
    logic [3:0]  gnt;
    logic [1:0]  rd_addr;
    logic [3:0]  rd_data;
    logic [15:0] q_all;

    int total = 0;
    int bad   = 0;

    pipo_rr_writer #(.NREQ(4), .WIDTH(4), .NREGS(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .hold     (hold),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .gnt      (gnt),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .q_all    (q_all)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset    = 1'b1;
        hold     = 1'b0;
        req      = 4'b0000;
        req_addr = 8'h00;
        req_data = 16'h0000;
        rd_addr  = 2'd0;
        #1;
        chk("rst_q_all", q_all, 16'h0000);
        chk("rst_gnt", {12'h0, gnt}, 16'h0000);
        chk("rst_rd", {12'h0, rd_data}, 16'h0000);
        tick();
        reset = 1'b0;

        // single write: requester 0 -> reg 2 = 0xA
        req      = 4'b0001;
        req_addr = 8'b00_00_00_10;
        req_data = 16'h000A;
        tick();
        chk("single_gnt", {12'h0, gnt}, 16'h0001);
        chk("single_q", {12'h0, q_all[11:8]}, 16'h000A);
        req     = 4'b0000;
        rd_addr = 2'd2;
        tick();
        chk("single_rd", {12'h0, rd_data}, 16'h000A);

        // traffic then async reset between edges
        req      = 4'b1111;
        req_addr = 8'b11_10_01_00;
        req_data = 16'h1234;
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("arst_q_all", q_all, 16'h0000);
        chk("arst_gnt", {12'h0, gnt}, 16'h0000);
        chk("arst_rd", {12'h0, rd_data}, 16'h0000);
        req = 4'b0000;
        #2;
        reset = 1'b0;

        // all four continuously: addr_i=i, data_i=i+5
        req      = 4'b1111;
        req_addr = 8'b11_10_01_00;
        req_data = 16'h8765;
        tick();
        chk("rr_g0", {12'h0, gnt}, 16'h0001);
        tick();
        chk("rr_g1", {12'h0, gnt}, 16'h0002);
        tick();
        chk("rr_g2", {12'h0, gnt}, 16'h0004);
        tick();
        chk("rr_g3", {12'h0, gnt}, 16'h0008);
        tick();
        chk("rr_g4", {12'h0, gnt}, 16'h0001);
        req = 4'b0000;
        tick();
        chk("rr_q_all", q_all, 16'h8765);
        chk("rr_idle", {12'h0, gnt}, 16'h0000);

        // requester 0 alone: one grant every other cycle
        req = 4'b0001;
        tick();
        chk("b2b_0", {12'h0, gnt}, 16'h0001);
        tick();
        chk("b2b_1", {12'h0, gnt}, 16'h0000);
        tick();
        chk("b2b_2", {12'h0, gnt}, 16'h0001);
        tick();
        chk("b2b_3", {12'h0, gnt}, 16'h0000);
        req = 4'b0000;

        // hold: no grants, no writes, reads still work
        hold     = 1'b1;
        req      = 4'b1111;
        req_data = 16'hFFFF;
        rd_addr  = 2'd3;
        tick();
        chk("hold_g0", {12'h0, gnt}, 16'h0000);
        chk("hold_q0", q_all, 16'h8765);
        chk("hold_rd", {12'h0, rd_data}, 16'h0008);
        tick();
        chk("hold_g1", {12'h0, gnt}, 16'h0000);
        chk("hold_q1", q_all, 16'h8765);
        tick();
        chk("hold_g2", {12'h0, gnt}, 16'h0000);
        chk("hold_q2", q_all, 16'h8765);
        hold = 1'b0;

        // collision: req 1 and 3 both to reg 0 (ptr is 1)
        req      = 4'b1010;
        req_addr = 8'b00_00_00_00;
        req_data = 16'h7030;
        tick();
        chk("col_g1", {12'h0, gnt}, 16'h0002);
        chk("col_q1", {12'h0, q_all[3:0]}, 16'h0003);
        tick();
        chk("col_g3", {12'h0, gnt}, 16'h0008);
        chk("col_q3", {12'h0, q_all[3:0]}, 16'h0007);
        req = 4'b0000;
        tick();
        chk("col_idle", {12'h0, gnt}, 16'h0000);

        // read-during-write on reg 1
        req      = 4'b0010;
        req_addr = 8'b00_00_01_00;
        req_data = 16'h0040;
        tick();
        chk("rdw_pre", {12'h0, q_all[7:4]}, 16'h0004);
        req      = 4'b0100;
        req_addr = 8'b00_01_00_00;
        req_data = 16'h0C00;
        rd_addr  = 2'd1;
        tick();
        chk("rdw_gnt", {12'h0, gnt}, 16'h0004);
        chk("rdw_old", {12'h0, rd_data}, 16'h0004);
        chk("rdw_q", {12'h0, q_all[7:4]}, 16'h000C);
        req = 4'b0000;
        tick();
        chk("rdw_new", {12'h0, rd_data}, 16'h000C);
        chk("final_q", q_all, 16'h87C7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
